// File: rtl/macro_broadcast_fork.sv
// One-entry broadcast fork: holds one producer beat and delivers it once to every consumer.
// Optional synchronous flush port is enabled by defining MACRO_BROADCAST_FORK_FLUSH_EN.
module macro_broadcast_fork #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned OUTPUT_COUNT = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
`ifdef MACRO_BROADCAST_FORK_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic [OUTPUT_COUNT-1:0] m_valid,
  input  logic [OUTPUT_COUNT-1:0] m_ready,
  output logic [DATA_WIDTH-1:0]   m_data
);

  logic                    full_q, full_d;
  logic [OUTPUT_COUNT-1:0] done_q, done_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [OUTPUT_COUNT-1:0] accept;
  logic                    last;
  logic                    s_hs;
  logic                    flush_w;

`ifdef MACRO_BROADCAST_FORK_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  always_comb begin
    m_valid = flush_w ? '0 : ({OUTPUT_COUNT{full_q}} & ~done_q);
    accept  = m_valid & m_ready;
    // last: every consumer has either taken the beat already or takes it this cycle
    last    = full_q & (&(done_q | accept));
    s_ready = ~flush_w & (~full_q | last);
    s_hs    = s_valid & s_ready;
    m_data  = data_q;
  end

  always_comb begin
    full_d = full_q;
    done_d = done_q | accept;
    data_d = data_q;
    if (flush_w) begin
      full_d = 1'b0;
      done_d = '0;
    end else if (s_hs) begin
      // Load takes priority over the drain so back-to-back beats have no bubble
      full_d = 1'b1;
      done_d = '0;
      data_d = s_data;
    end else if (last) begin
      full_d = 1'b0;
      done_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q <= 1'b0;
      done_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      done_q <= done_d;
      data_q <= data_d;
    end
  end

endmodule

// File: tb/tb_macro_broadcast_fork.sv
// Scoreboard bench for macro_broadcast_fork (4 consumers, 8-bit data); directed vectors.
module tb_macro_broadcast_fork;

  logic       clk = 1'b0;
  logic       resetn;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] m_data;
`ifdef MACRO_BROADCAST_FORK_FLUSH_EN
  logic       flush;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_beats[$];
  int rd[4];

  always #5 clk = ~clk;

  macro_broadcast_fork #(
    .DATA_WIDTH  (8),
    .OUTPUT_COUNT(4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
`ifdef MACRO_BROADCAST_FORK_FLUSH_EN
    .flush  (flush),
`endif
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every consumer handshake must deliver that consumer's next expected beat
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i] && m_ready[i]) begin
          if (rd[i] < exp_beats.size()) begin
            chk($sformatf("deliver_c%0d_b%0d", i, rd[i]), {24'd0, m_data}, {24'd0, exp_beats[rd[i]]});
            rd[i]++;
          end else begin
            n_vec++;
            n_err++;
            $display("FAIL extra_delivery_c%0d: got data %0h, expected no beat", i, m_data);
          end
        end
      end
    end
  end

  // Check control outputs at the falling edge, then advance to just after the next rising edge
  task automatic tick(input string name, input logic [3:0] exp_mv, input logic exp_sr);
    @(negedge clk);
    chk({name, "_m_valid"}, {28'd0, m_valid}, {28'd0, exp_mv});
    chk({name, "_s_ready"}, {31'd0, s_ready}, {31'd0, exp_sr});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [7:0] sd, input logic [3:0] mr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
  endtask

  task automatic discard_held();
    for (int i = 0; i < 4; i++) rd[i] = exp_beats.size();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) rd[i] = 0;
    resetn = 1'b0;
    drive(1'b0, 8'h00, 4'h0);
`ifdef MACRO_BROADCAST_FORK_FLUSH_EN
    flush = 1'b0;
`endif
    #8;
    chk("reset_m_valid", {28'd0, m_valid}, 32'h0);
    chk("reset_m_data",  {24'd0, m_data},  32'h0);
    chk("reset_s_ready", {31'd0, s_ready}, 32'h1);
    #4 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate
    drive(1'b1, 8'h01, 4'hF); exp_beats.push_back(8'h01); tick("stream0", 4'h0, 1'b1);
    drive(1'b1, 8'h02, 4'hF); exp_beats.push_back(8'h02); tick("stream1", 4'hF, 1'b1);
    drive(1'b1, 8'h03, 4'hF); exp_beats.push_back(8'h03); tick("stream2", 4'hF, 1'b1);
    drive(1'b0, 8'h00, 4'hF); tick("stream3", 4'hF, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("stream_idle", 4'h0, 1'b1);

    // Out-of-order partial acceptance
    drive(1'b1, 8'hA5, 4'h0); exp_beats.push_back(8'hA5); tick("ooo_load", 4'h0, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("ooo_hold", 4'hF, 1'b0);
    drive(1'b0, 8'h00, 4'b0001); tick("ooo_r0", 4'hF, 1'b0);
    drive(1'b0, 8'h00, 4'b0100); tick("ooo_r2", 4'hE, 1'b0);
    drive(1'b0, 8'h00, 4'b1010); tick("ooo_r13", 4'hA, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("ooo_empty", 4'h0, 1'b1);

    // Last consumer accepts while the next beat loads: no bubble
    drive(1'b1, 8'h11, 4'h0); exp_beats.push_back(8'h11); tick("b2b_load", 4'h0, 1'b1);
    drive(1'b0, 8'h00, 4'b0111); tick("b2b_part", 4'hF, 1'b0);
    drive(1'b1, 8'h22, 4'b1000); exp_beats.push_back(8'h22); tick("b2b_last", 4'h8, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("b2b_next", 4'hF, 1'b0);
    drive(1'b0, 8'h00, 4'hF); tick("b2b_drain", 4'hF, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("b2b_empty", 4'h0, 1'b1);

    // Backpressure: held beat stays put while the producer keeps offering data
    drive(1'b1, 8'h33, 4'h0); exp_beats.push_back(8'h33); tick("bp_load", 4'h0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 8'h40 + 8'(k), 4'h0);
      @(negedge clk);
      chk($sformatf("bp_data_%0d", k), {24'd0, m_data}, 32'h33);
      @(posedge clk);
      #1;
      chk($sformatf("bp_ctl_%0d", k), {27'd0, m_valid, s_ready}, {27'd0, 4'hF, 1'b0});
    end
    drive(1'b0, 8'h00, 4'hF); tick("bp_drain", 4'hF, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("bp_empty", 4'h0, 1'b1);

    // Reset in the middle of a delivery
    drive(1'b1, 8'h5A, 4'h0); exp_beats.push_back(8'h5A); tick("rst_load", 4'h0, 1'b1);
    drive(1'b0, 8'h00, 4'b0011); tick("rst_part", 4'hF, 1'b0);
    drive(1'b0, 8'h00, 4'h0); tick("rst_held", 4'hC, 1'b0);
    resetn = 1'b0;
    #1;
    chk("rst_m_valid", {28'd0, m_valid}, 32'h0);
    chk("rst_m_data",  {24'd0, m_data},  32'h0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'h1);
    discard_held();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 8'h77, 4'h0); exp_beats.push_back(8'h77); tick("post_rst_load", 4'h0, 1'b1);
    drive(1'b0, 8'h00, 4'hF); tick("post_rst_all", 4'hF, 1'b1);
    drive(1'b0, 8'h00, 4'h0); tick("post_rst_empty", 4'h0, 1'b1);

`ifdef MACRO_BROADCAST_FORK_FLUSH_EN
    drive(1'b1, 8'h99, 4'h0); exp_beats.push_back(8'h99); tick("fl_load", 4'h0, 1'b1);
    drive(1'b0, 8'h00, 4'b0001); tick("fl_part", 4'hF, 1'b0);
    flush = 1'b1;
    drive(1'b1, 8'hEE, 4'hF); tick("fl_flush", 4'h0, 1'b0);
    discard_held();
    flush = 1'b0;
    drive(1'b0, 8'h00, 4'h0); tick("fl_after", 4'h0, 1'b1);
`endif

    for (int i = 0; i < 4; i++)
      chk($sformatf("delivered_count_c%0d", i), rd[i], exp_beats.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
